// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// The sequence is: hold the clock low (inhibit), request-to-send with the
// start bit on data, then shift out 8 data bits LSB first, an odd-parity
// bit and a stop bit on device clock falls, and finally sample the
// device acknowledge.
// The bus is driven only through open-collector pull-low enables.
//
// Optional feature: define PS2TX_TIMEOUT_EN to build in a watchdog. It
// aborts a transfer when the device stops clocking.
//
// Handshake: send_request is accepted only in IDLE when not busy. The
// byte is latched in that cycle. busy stays high from the cycle after
// acceptance through the done/error cycle. done and error are mutually
// exclusive single-cycle pulses.
module ps2_host_tx #(
    parameter logic [15:0] INHIBIT_CYCLES = 16'd5000,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd300000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       device_clock,
    input  logic       device_data,
    input  logic       send_request,
    input  logic [7:0] send_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       clock_drive_low,
    output logic       data_drive_low,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_XFER      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  shift_q, shift_d;
    logic        prev_clk_q, prev_clk_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        clk_low_q, clk_low_d;
    logic        data_low_q, data_low_d;
    logic        fall;

`ifdef PS2TX_TIMEOUT_EN
    logic [19:0] wd_q, wd_d;
    logic        clock_edge;
    logic        watched;
`else
    // Without the watchdog the timeout parameter has no consumer. This
    // empty generate keeps it referenced so the interface is the same in
    // both builds.
    if (TIMEOUT_CYCLES == 20'd0) begin : g_no_watchdog
    end
`endif

    assign fall = prev_clk_q & ~device_clock;

    // Next-state and next-output computation for the whole transfer sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        prev_clk_d = device_clock;

        case (state_q)
            S_IDLE: begin
                // busy may still be high here for one cycle after a timeout abort
                busy_d     = 1'b0;
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (send_request && !busy_q) begin
                    shift_d   = {1'b1, ~^send_data, send_data};
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                    cnt_d     = 16'd0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INHIBIT_CYCLES - 16'd1) begin
                    data_low_d = 1'b1;
                    state_d    = S_RTS;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RTS: begin
                clk_low_d = 1'b0;
                bit_cnt_d = 4'd0;
                state_d   = S_XFER;
            end
            S_XFER: begin
                // Falls 1..10 present D0..D7, parity, then the stop bit (released line)
                if (fall && bit_cnt_q <= 4'd9) begin
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!device_data) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (device_clock && device_data) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PS2TX_TIMEOUT_EN
        clock_edge = prev_clk_q ^ device_clock;
        watched    = (state_q == S_XFER) || (state_q == S_ACK) ||
                     (state_q == S_WAIT_IDLE);
        if (!watched || clock_edge || (state_d != state_q)) begin
            wd_d = 20'd0;
        end else begin
            wd_d = wd_q + 20'd1;
        end
        if (watched && !clock_edge && (wd_q == TIMEOUT_CYCLES - 20'd1)) begin
            state_d    = S_IDLE;
            done_d     = 1'b0;
            error_d    = 1'b1;
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            wd_d       = 20'd0;
        end
`endif
    end

    // State and registered outputs; reset releases both bus lines at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 10'd0;
            prev_clk_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            prev_clk_q <= prev_clk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
        end
    end

`ifdef PS2TX_TIMEOUT_EN
    // Cycles since the last device clock transition while the device owns the clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q <= 20'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign clock_drive_low = clk_low_q;
    assign data_drive_low  = data_low_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a wired-AND bus with a behavioural PS/2 device,
// and a frame reference model derived from the byte (start, LSB-first
// data, odd parity, stop).
module tb_ps2_host_tx;

    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       send_request = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       busy, done, error, clock_drive_low, data_drive_low;
    logic [2:0] state_dbg;
    logic       device_clock, device_data;

    int total = 0;
    int passed = 0;
    int done_cycles = 0;
    int error_cycles = 0;
    int both_cycles = 0;
    int pulse_no_busy = 0;
    int cyc = 0;
    int last_edge_cyc = 0;
    logic [10:0] dev_got;
    logic [10:0] exp_q[$];

    // Open-collector bus: either side may pull a line low
    assign device_clock = dev_clk & ~clock_drive_low;
    assign device_data  = dev_data & ~data_drive_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(16'd8),
        .TIMEOUT_CYCLES(20'd1000)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .device_clock(device_clock),
        .device_data(device_data),
        .send_request(send_request),
        .send_data(send_data),
        .busy(busy),
        .done(done),
        .error(error),
        .clock_drive_low(clock_drive_low),
        .data_drive_low(data_drive_low),
        .state_dbg(state_dbg)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Pulse monitor
    always @(negedge clock) begin
        if (done) done_cycles++;
        if (error) error_cycles++;
        if (done && error) both_cycles++;
        if ((done || error) && !busy) pulse_no_busy++;
    end

    // Reference frame as the device should see it on the wire
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        int ones;
        logic [10:0] f;
        ones = 0;
        f = 11'd0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i+1] = b[i];
        end
        f[0]  = 1'b0;
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_req(input logic [7:0] b);
        @(negedge clock);
        send_request = 1'b1;
        send_data = b;
        exp_q.push_back(exp_frame(b));
        @(negedge clock);
        send_request = 1'b0;
        send_data = 8'($urandom);
    endtask

    // Device waits for the host to release clock with the start bit on data
    task automatic dev_wait_rts(output bit ok);
        ok = 1'b0;
        dev_got = 11'd0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!clock_drive_low && data_drive_low) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clock);
        dev_got[0] = device_data;
    endtask

    // Device clocks falls first..last, reading each bit while the clock is low
    task automatic dev_falls(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            dev_got[k] = device_data;
            dev_clk = 1'b1;
            last_edge_cyc = cyc;
            repeat (HALF) @(negedge clock);
        end
    endtask

    task automatic dev_ack(input bit ack);
        if (ack) dev_data = 1'b0;
        repeat (2) @(negedge clock);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        dev_clk = 1'b1;
        repeat (2) @(negedge clock);
        dev_data = 1'b1;
    endtask

    task automatic wait_not_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, done, error, clock_drive_low, data_drive_low} !== 5'b0)
            $display("FAIL reset_hold: outputs %b expected 00000",
                     {busy, done, error, clock_drive_low, data_drive_low});
        else passed++;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, done, error, clock_drive_low, data_drive_low} !== 5'b0)
            $display("FAIL reset_idle: outputs %b expected 00000",
                     {busy, done, error, clock_drive_low, data_drive_low});
        else passed++;
    endtask

    task automatic run_send(input logic [7:0] b, input bit ack, input string name);
        int d0, e0;
        bit ok, ok2;
        logic [10:0] exp;
        d0 = done_cycles;
        e0 = error_cycles;
        start_req(b);
        dev_wait_rts(ok);
        dev_falls(1, 10);
        dev_ack(ack);
        wait_not_busy(ok2);
        exp = exp_q.pop_front();
        total++;
        if (!ok || dev_got !== exp)
            $display("FAIL %s frame: got %b expected %b (rts seen %0d)", name, dev_got, exp, ok);
        else passed++;
        total++;
        if (done_cycles - d0 !== (ack ? 1 : 0))
            $display("FAIL %s done: got %0d cycles expected %0d", name, done_cycles - d0, ack ? 1 : 0);
        else passed++;
        total++;
        if (error_cycles - e0 !== (ack ? 0 : 1))
            $display("FAIL %s error: got %0d cycles expected %0d", name, error_cycles - e0, ack ? 0 : 1);
        else passed++;
        total++;
        if (!ok2 || {busy, clock_drive_low, data_drive_low} !== 3'b000)
            $display("FAIL %s idle: busy/clk/data %b expected 000", name,
                     {busy, clock_drive_low, data_drive_low});
        else passed++;
    endtask

    task automatic test_inhibit();
        int clk_cycles, data_rise;
        bit ok, ok2;
        logic [10:0] exp;
        logic [7:0] b;
        b = 8'($urandom);
        start_req(b);
        total++;
        if ({busy, clock_drive_low, data_drive_low} !== 3'b110)
            $display("FAIL accept: busy/clk/data %b expected 110",
                     {busy, clock_drive_low, data_drive_low});
        else passed++;
        clk_cycles = 1;
        data_rise = -1;
        for (int i = 1; i < 100; i++) begin
            @(negedge clock);
            if (data_drive_low && data_rise < 0) data_rise = i;
            if (clock_drive_low) clk_cycles++;
            else break;
        end
        total++;
        if (clk_cycles !== 9)
            $display("FAIL inhibit_len: clock low %0d cycles expected 9", clk_cycles);
        else passed++;
        total++;
        if (data_rise !== 8)
            $display("FAIL start_bit: data low at %0d cycles expected 8", data_rise);
        else passed++;
        dev_wait_rts(ok);
        dev_falls(1, 10);
        dev_ack(1'b1);
        wait_not_busy(ok2);
        exp = exp_q.pop_front();
        total++;
        if (!ok || !ok2 || dev_got !== exp)
            $display("FAIL inhibit_frame: got %b expected %b", dev_got, exp);
        else passed++;
    endtask

    task automatic test_busy_guard();
        int d0, busy_seen;
        bit ok, ok2;
        logic [10:0] exp;
        logic [7:0] b;
        b = 8'($urandom);
        d0 = done_cycles;
        start_req(b);
        dev_wait_rts(ok);
        dev_falls(1, 2);
        @(negedge clock);
        send_request = 1'b1;
        send_data = ~b;
        @(negedge clock);
        send_request = 1'b0;
        dev_falls(3, 10);
        dev_ack(1'b1);
        wait_not_busy(ok2);
        exp = exp_q.pop_front();
        total++;
        if (!ok || !ok2 || dev_got !== exp)
            $display("FAIL guard_frame: got %b expected %b", dev_got, exp);
        else passed++;
        total++;
        if (done_cycles - d0 !== 1)
            $display("FAIL guard_done: got %0d cycles expected 1", done_cycles - d0);
        else passed++;
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (busy) busy_seen++;
        end
        total++;
        if (busy_seen !== 0)
            $display("FAIL guard_queue: busy for %0d cycles expected 0", busy_seen);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        bit ok;
        logic [7:0] b;
        logic [10:0] exp;
        b = 8'($urandom) & 8'hF7;
        d0 = done_cycles;
        e0 = error_cycles;
        start_req(b);
        dev_wait_rts(ok);
        dev_falls(1, 4);
        @(negedge clock);
        total++;
        if (!ok || {busy, data_drive_low} !== 2'b11)
            $display("FAIL pre_reset: busy/data %b expected 11", {busy, data_drive_low});
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, error, clock_drive_low, data_drive_low} !== 5'b0)
            $display("FAIL async_reset: outputs %b expected 00000",
                     {busy, done, error, clock_drive_low, data_drive_low});
        else passed++;
        exp = exp_q.pop_front();
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        total++;
        if ((done_cycles - d0) !== 0 || (error_cycles - e0) !== 0)
            $display("FAIL reset_pulse: done %0d error %0d expected 0 0 (frame %b)",
                     done_cycles - d0, error_cycles - e0, exp);
        else passed++;
        run_send(8'($urandom), 1'b1, "after_reset");
    endtask

`ifdef PS2TX_TIMEOUT_EN
    task automatic test_timeout();
        int delta;
        bit ok, seen;
        logic [10:0] exp;
        start_req(8'($urandom));
        dev_wait_rts(ok);
        dev_falls(1, 3);
        seen = 1'b0;
        delta = -1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clock);
            if (error) begin
                seen = 1'b1;
                delta = cyc - last_edge_cyc;
                break;
            end
        end
        total++;
        if (!ok || !seen || delta < 1000 || delta > 1002)
            $display("FAIL timeout_delay: error after %0d cycles expected 1000..1002", delta);
        else passed++;
        total++;
        if ({clock_drive_low, data_drive_low} !== 2'b00)
            $display("FAIL timeout_release: clk/data %b expected 00", {clock_drive_low, data_drive_low});
        else passed++;
        @(negedge clock);
        total++;
        if ({busy, error} !== 2'b00)
            $display("FAIL timeout_idle: busy/error %b expected 00", {busy, error});
        else passed++;
        exp = exp_q.pop_front();
        if (exp[10] !== 1'b1) $display("note: unexpected model frame %b", exp);
        run_send(8'($urandom), 1'b1, "after_timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_inhibit();
        run_send(8'hED, 1'b1, "led_cmd");
        run_send(8'h00, 1'b1, "zero_byte");
        run_send(8'hFF, 1'b0, "missing_ack");
        for (int i = 0; i < 4; i++) begin
            run_send(8'($urandom), ($urandom_range(0, 3) != 0), "random");
        end
        test_busy_guard();
        test_reset_mid();
`ifdef PS2TX_TIMEOUT_EN
        test_timeout();
`endif
        total++;
        if (both_cycles !== 0 || pulse_no_busy !== 0)
            $display("FAIL pulse_rules: both %0d unbusy %0d expected 0 0", both_cycles, pulse_no_busy);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
